rmw_sram_adapter: RTL

RMW_SRAM_ADAPTER -- requirements
Module: rmw_sram_adapter

---
 rtl/rmw_sram_if.sv | 30 +++
 rtl/rmw_sram_adapter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rmw_sram_if.sv
// Bus bundle between a word-oriented master, the RMW adapter and a synchronous SRAM.
// The slave modport is the adapter's view; the master modport drives requests and models the RAM.
interface rmw_sram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  read_i;
    logic                  write_i;
    logic [DATA_W/8-1:0]   byteenable_i;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     data_master_wr;
    logic                  stall_o;
    logic [DATA_W-1:0]     data_master_rd;
    logic                  rd_valid_o;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  read_o;
    logic                  write_o;
    logic [DATA_W-1:0]     data_ram_wr;
    logic [DATA_W-1:0]     data_ram_rd;

    modport slave (
        input  read_i, write_i, byteenable_i, address, data_master_wr, data_ram_rd,
        output stall_o, data_master_rd, rd_valid_o, ram_addr, read_o, write_o, data_ram_wr
    );

    modport master (
        output read_i, write_i, byteenable_i, address, data_master_wr, data_ram_rd,
        input  stall_o, data_master_rd, rd_valid_o, ram_addr, read_o, write_o, data_ram_wr
    );
endinterface

// File: rtl/rmw_sram_adapter.sv
// Byte-enable adapter for a word-only SRAM: full writes pass through, partial writes
// become read-merge-write sequences, reads wait out the RAM latency.
//
// state   | meaning
// IDLE    | accepting requests; full/empty writes complete here
// RD_WAIT | RAM read in flight, counter runs down to the data-valid cycle
// WR      | merged word written back, stall released
module rmw_sram_adapter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    rmw_sram_if.slave        bus,
    output logic [CNT_W-1:0] rmw_count,
    output logic             err_o
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [NB-1:0]       lat_be;
    logic [DATA_W-1:0]   lat_data;
    logic                lat_is_rd;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   merge_word;
    logic                be_full, be_empty, take_partial, take_read, rd_done;

    assign be_full      = &bus.byteenable_i;
    assign be_empty     = ~|bus.byteenable_i;
    // A simultaneous read+write is treated as the write.
    assign take_partial = (state == IDLE) && bus.write_i && !be_full && !be_empty;
    assign take_read    = (state == IDLE) && bus.read_i && !bus.write_i;
    assign rd_done      = (state == RD_WAIT) && (cnt == '0);

    always_comb begin
        merge_word = '0;
        for (int b = 0; b < NB; b++) begin
            merge_word[b*8 +: 8] = lat_be[b] ? lat_data[b*8 +: 8] : bus.data_ram_rd[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_partial || take_read) state_nxt = RD_WAIT;
            RD_WAIT: if (cnt == '0) state_nxt = lat_is_rd ? IDLE : WR;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_data  <= '0;
            lat_is_rd <= 1'b0;
            merged    <= '0;
            rmw_count <= '0;
            err_o     <= 1'b0;
        end else begin
            if (take_partial || take_read) begin
                cnt       <= CW'(RD_LAT - 1);
                lat_addr  <= bus.address;
                lat_be    <= bus.byteenable_i;
                lat_data  <= bus.data_master_wr;
                lat_is_rd <= take_read;
            end else if (state == RD_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (rd_done && !lat_is_rd) merged <= merge_word;
            if (state == WR) rmw_count <= rmw_count + CNT_W'(1);
            if (state == IDLE && bus.read_i && bus.write_i) err_o <= 1'b1;
        end
    end

    // Strobes and data are forced low during reset so an abandoned RMW never reaches the RAM.
    always_comb begin
        bus.ram_addr       = (state == IDLE) ? bus.address : lat_addr;
        bus.stall_o        = 1'b0;
        bus.read_o         = 1'b0;
        bus.write_o        = 1'b0;
        bus.rd_valid_o     = 1'b0;
        bus.data_master_rd = '0;
        bus.data_ram_wr    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.write_i) begin
                        if (be_full) begin
                            bus.write_o     = 1'b1;
                            bus.data_ram_wr = bus.data_master_wr;
                        end else if (!be_empty) begin
                            bus.read_o  = 1'b1;
                            bus.stall_o = 1'b1;
                        end
                    end else if (bus.read_i) begin
                        bus.read_o  = 1'b1;
                        bus.stall_o = 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rd_done && lat_is_rd) begin
                        bus.rd_valid_o     = 1'b1;
                        bus.data_master_rd = bus.data_ram_rd;
                    end else begin
                        bus.stall_o = 1'b1;
                    end
                end
                WR: begin
                    bus.write_o     = 1'b1;
                    bus.data_ram_wr = merged;
                end
                default: ;
            endcase
        end
    end
endmodule
